// File: rtl/cdr_dlf_pi.sv
// Second-order bang-bang CDR loop filter driving a circular phase-interpolator code.
// BBPD up/dn decisions are majority-voted over a DECIM-cycle window. Each window's
// vote feeds a proportional path and a saturating integral (frequency) path.
// Freeze holds the loop state but keeps the window running. A lock detector
// counts consecutive balanced windows.
module cdr_dlf_pi #(
  parameter int CODE_W    = 11,
  parameter int ACC_W     = 16,
  parameter int DECIM     = 4,
  parameter int KP        = 2,
  parameter int KI_SHIFT  = 4,
  parameter int CODE_INIT = 0,
  parameter int LOCK_CNT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up,
  input  logic              dn,
  input  logic              freeze,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic [ACC_W-1:0]  integ,
  output logic              locked
);

  localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SUM_W  = $clog2(DECIM) + 2;
  localparam int LCK_W  = $clog2(LOCK_CNT + 1);
  localparam int STEP_W = ACC_W + 2;
  localparam int SX_W   = (CODE_W > STEP_W) ? CODE_W : STEP_W;

  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(DECIM - 1);
  localparam logic signed [SUM_W-1:0]  DEC_POS   = SUM_W'(DECIM);
  localparam logic signed [SUM_W-1:0]  DEC_NEG   = SUM_W'(-DECIM);
  localparam logic signed [ACC_W:0]    SAT_HI    = (ACC_W+1)'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0]    SAT_LO    = -SAT_HI;
  localparam logic signed [STEP_W-1:0] KP_S      = STEP_W'(KP);
  localparam logic [LCK_W-1:0]         LOCK_FULL = LCK_W'(LOCK_CNT);
  localparam logic [CODE_W-1:0]        CODE_RST  = CODE_W'(CODE_INIT);

  logic [CNT_W-1:0]         cnt;
  logic signed [SUM_W-1:0]  sum;
  logic [LCK_W-1:0]         lock_cnt;
  logic signed [ACC_W-1:0]  integ_r;
  logic [CODE_W-1:0]        code_r;

  logic signed [1:0]        v;
  logic                     win_end;
  logic signed [SUM_W-1:0]  total;
  logic signed [1:0]        s;
  logic                     balanced;
  logic signed [ACC_W:0]    integ_sum;
  logic signed [ACC_W-1:0]  integ_n;
  logic signed [STEP_W-1:0] integ_x;
  logic signed [STEP_W-1:0] step;
  logic signed [SX_W-1:0]   step_x;
  logic [CODE_W-1:0]        code_n;
  logic [LCK_W-1:0]         lock_n;

  assign code  = code_r;
  assign integ = integ_r;

  // Per-cycle vote and the running window total including the current sample
  always_comb begin
    v = 2'sd0;
    if (up && !dn) begin
      v = 2'sd1;
    end else if (dn && !up) begin
      v = -2'sd1;
    end
    win_end  = (cnt == CNT_LAST);
    total    = sum + {{(SUM_W-2){v[1]}}, v};
    s        = 2'sd0;
    if (total > 0) begin
      s = 2'sd1;
    end else if (total < 0) begin
      s = -2'sd1;
    end
    balanced = (total < DEC_POS) && (total > DEC_NEG);
  end

  // Saturating integrator, proportional+integral step and wrapped next code
  always_comb begin
    integ_sum = {integ_r[ACC_W-1], integ_r} + {{(ACC_W-1){s[1]}}, s};
    integ_n   = integ_sum[ACC_W-1:0];
    if (integ_sum > SAT_HI) begin
      integ_n = SAT_HI[ACC_W-1:0];
    end else if (integ_sum < SAT_LO) begin
      integ_n = SAT_LO[ACC_W-1:0];
    end
    integ_x = {{2{integ_n[ACC_W-1]}}, integ_n};
    step    = ({{(STEP_W-2){s[1]}}, s} * KP_S) + (integ_x >>> KI_SHIFT);
    step_x  = SX_W'(step);
    code_n  = code_r + step_x[CODE_W-1:0];
  end

  // Lock counter next value: saturates on balanced windows, clears otherwise
  always_comb begin
    lock_n = '0;
    if (balanced) begin
      lock_n = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + 1'b1;
    end
  end

  // Window sequencing and loop state update at each non-frozen window end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sum        <= '0;
      lock_cnt   <= '0;
      integ_r    <= '0;
      code_r     <= CODE_RST;
      code_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (win_end) begin
        cnt <= '0;
        sum <= '0;
        if (!freeze) begin
          integ_r    <= integ_n;
          code_r     <= code_n;
          code_valid <= 1'b1;
          lock_cnt   <= lock_n;
          locked     <= (lock_n == LOCK_FULL);
        end
      end else begin
        cnt <= cnt + 1'b1;
        sum <= total;
      end
    end
  end

endmodule

// File: tb/tb_cdr_dlf_pi.sv
// Directed testbench for cdr_dlf_pi: a table of per-window vectors with
// hand-computed results, plus sequences for reset, steady tracking, lock,
// freeze and integrator saturation.
module tb_cdr_dlf_pi;

  logic        clk;
  logic        rst_n;
  logic        up;
  logic        dn;
  logic        freeze;
  logic [10:0] code;
  logic        code_valid;
  logic [15:0] integ;
  logic        locked;
  logic [10:0] code2;
  logic        code_valid2;
  logic [5:0]  integ2;
  logic        locked2;

  int total;
  int bad;

  typedef struct {
    logic [3:0] up_pat;
    logic [3:0] dn_pat;
    logic       frz;
    int         exp_code;
    int         exp_integ;
    int         exp_locked;
    int         exp_valid;
  } vec_t;

  vec_t vecs[14];

  cdr_dlf_pi dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up),
    .dn         (dn),
    .freeze     (freeze),
    .code       (code),
    .code_valid (code_valid),
    .integ      (integ),
    .locked     (locked)
  );

  cdr_dlf_pi #(.ACC_W(6), .KI_SHIFT(0)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up),
    .dn         (dn),
    .freeze     (freeze),
    .code       (code2),
    .code_valid (code_valid2),
    .integ      (integ2),
    .locked     (locked2)
  );

  // 10-unit reference clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    up     = 1'b0;
    dn     = 1'b0;
    freeze = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  // Drive one full window; returns number of code_valid pulses seen and the final one
  task automatic apply_stimulus(input logic [3:0] up_pat, input logic [3:0] dn_pat,
                                input logic frz, output int nvalid, output int last_valid);
    nvalid = 0;
    last_valid = 0;
    for (int c = 0; c < 4; c++) begin
      up     = up_pat[c];
      dn     = dn_pat[c];
      freeze = frz;
      @(posedge clk);
      #1;
      nvalid += int'(code_valid);
      last_valid = int'(code_valid);
    end
  endtask

  initial begin
    int nv;
    int lv;
    int edges;
    total  = 0;
    bad    = 0;
    up     = 1'b0;
    dn     = 1'b0;
    freeze = 1'b0;
    rst_n  = 1'b1;
    #2;

    // ---------------- table-driven windows from reset ----------------
    vecs[0]  = '{4'hF, 4'h0, 1'b0,    2,  1, 0, 1};
    vecs[1]  = '{4'h0, 4'hF, 1'b0,    0,  0, 0, 1};
    vecs[2]  = '{4'h0, 4'hF, 1'b0, 2045, -1, 0, 1};
    vecs[3]  = '{4'hF, 4'h0, 1'b0, 2047,  0, 0, 1};
    vecs[4]  = '{4'hF, 4'h0, 1'b0,    1,  1, 0, 1};
    vecs[5]  = '{4'hA, 4'h5, 1'b0,    1,  1, 0, 1};
    vecs[6]  = '{4'hF, 4'hF, 1'b0,    1,  1, 0, 1};
    vecs[7]  = '{4'h7, 4'h0, 1'b0,    3,  2, 0, 1};
    vecs[8]  = '{4'hF, 4'h0, 1'b1,    3,  2, 0, 0};
    vecs[9]  = '{4'h0, 4'h0, 1'b0,    3,  2, 0, 1};
    vecs[10] = '{4'h0, 4'h0, 1'b0,    3,  2, 0, 1};
    vecs[11] = '{4'h0, 4'h0, 1'b0,    3,  2, 0, 1};
    vecs[12] = '{4'h0, 4'h0, 1'b0,    3,  2, 0, 1};
    vecs[13] = '{4'h0, 4'h0, 1'b0,    3,  2, 1, 1};

    do_reset();
    check_output("reset_code", int'(code), 0);
    check_output("reset_integ", int'($signed(integ)), 0);
    check_output("reset_locked", int'(locked), 0);
    check_output("reset_valid", int'(code_valid), 0);
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].up_pat, vecs[i].dn_pat, vecs[i].frz, nv, lv);
      check_output($sformatf("vec%0d_code", i), int'(code), vecs[i].exp_code);
      check_output($sformatf("vec%0d_integ", i), int'($signed(integ)), vecs[i].exp_integ);
      check_output($sformatf("vec%0d_locked", i), int'(locked), vecs[i].exp_locked);
      check_output($sformatf("vec%0d_valid", i), nv, vecs[i].exp_valid);
    end

    // ---------------- steady up: 16 windows ----------------
    do_reset();
    for (int w = 1; w <= 16; w++) begin
      apply_stimulus(4'hF, 4'h0, 1'b0, nv, lv);
      if (w == 1) begin
        check_output("steady_w1_code", int'(code), 2);
        check_output("steady_w1_integ", int'($signed(integ)), 1);
        check_output("steady_w1_valid", nv, 1);
      end
    end
    check_output("steady_w16_code", int'(code), 33);
    check_output("steady_w16_integ", int'($signed(integ)), 16);

    // ---------------- freeze ----------------
    do_reset();
    apply_stimulus(4'hF, 4'h0, 1'b0, nv, lv);
    check_output("frz_pre_code", int'(code), 2);
    for (int w = 0; w < 3; w++) begin
      apply_stimulus(4'hF, 4'h0, 1'b1, nv, lv);
      check_output($sformatf("frz%0d_code", w), int'(code), 2);
      check_output($sformatf("frz%0d_integ", w), int'($signed(integ)), 1);
      check_output($sformatf("frz%0d_valid", w), nv, 0);
    end
    apply_stimulus(4'hF, 4'h0, 1'b0, nv, lv);
    check_output("frz_post_code", int'(code), 4);
    check_output("frz_post_integ", int'($signed(integ)), 2);
    check_output("frz_post_phase", lv, 1);

    // ---------------- lock detector ----------------
    do_reset();
    edges = 0;
    for (int w = 1; w <= 8; w++) begin
      apply_stimulus(4'hA, 4'h5, 1'b0, nv, lv);
      edges += 4;
      if (w == 7) check_output("lock_w7", int'(locked), 0);
      if (w == 2) check_output("lock_valid_s0", nv, 1);
    end
    check_output("lock_w8", int'(locked), 1);
    check_output("lock_edges", edges, 32);
    check_output("lock_code", int'(code), 0);
    apply_stimulus(4'hF, 4'h0, 1'b0, nv, lv);
    check_output("lock_drop", int'(locked), 0);
    check_output("lock_drop_code", int'(code), 2);
    for (int w = 0; w < 8; w++) apply_stimulus(4'hA, 4'h5, 1'b0, nv, lv);
    check_output("relock", int'(locked), 1);
    check_output("relock_code", int'(code), 2);

    // ---------------- asynchronous reset mid-window ----------------
    up = 1'b1;
    dn = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("async_code", int'(code), 0);
    check_output("async_integ", int'($signed(integ)), 0);
    check_output("async_locked", int'(locked), 0);
    check_output("async_valid", int'(code_valid), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    edges = 0;
    while (code_valid !== 1'b1 && edges < 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_output("async_first_valid_edges", edges, 4);
    check_output("async_first_code", int'(code), 2);

    // ---------------- saturation (ACC_W=6, KI_SHIFT=0 instance) ----------------
    do_reset();
    for (int w = 1; w <= 40; w++) begin
      apply_stimulus(4'hF, 4'h0, 1'b0, nv, lv);
      if (w == 30) check_output("sat_w30_integ", int'($signed(integ2)), 30);
      if (w == 31) begin
        check_output("sat_w31_integ", int'($signed(integ2)), 31);
        check_output("sat_w31_code", int'(code2), 558);
      end
    end
    check_output("sat_w40_integ", int'($signed(integ2)), 31);
    check_output("sat_w40_code", int'(code2), 855);
    apply_stimulus(4'hF, 4'hF, 1'b0, nv, lv);
    check_output("sat_updn_integ", int'($signed(integ2)), 31);
    check_output("sat_updn_code", int'(code2), 886);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
